uart_cmd_decoder: RTL and testbench
===================================

# uart_cmd_decoder

Parametrised successor to the fixed UART key-to-button decoder: it converts received UART command bytes into held button levels for the paddle logic. Each received byte is a one-cycle strobe; a matching key asserts its channel for a programmable hold time, retriggerable by key repeat. Opposing channels can be made mutually exclusive. A dedicated key produces a stretched game-reset pulse. Sits between the UART receiver and the game core, all on the 25 MHz domain.

## Interface
- NUM_CH, 4: number of button channels (1..16).
- KEY_MAP, {"p","l","q","a"}: packed 8*NUM_CH bits; byte i = key for channel i (default ch0='a', ch1='q', ch2='l', ch3='p').
- RST_KEY, "b": key that triggers game reset.
- HOLD_CYCLES, 2500000: cycles a channel stays asserted after its last key (100 ms at 25 MHz); must be >= 1.
- RST_PULSE_CYCLES, 16: game_rst pulse length in cycles; must be >= 1.
- PAIR_EXCL, 1: 1 = channels 2k and 2k+1 are mutually exclusive (up/down pairs).
- clk25MHz  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- rx_data  input  8  received byte; sampled only when rx_valid = 1.
- rx_valid  input  1  one-cycle strobe per received byte.
- btn  output  NUM_CH  held button levels, registered.
- game_rst  output  1  stretched game-reset pulse, registered.
- last_cmd  output  8  last byte that matched a channel or RST_KEY.
- cmd_count  output  8  recognised-byte count, saturating at 255.
- err_count  output  8  unrecognised-byte count, saturating at 255.

## Operation
- Per channel i: hold counter hcnt[i], width $clog2(HOLD_CYCLES+1).
- Accept condition: rx_valid=1 and game_rst=0. Bytes arriving while game_rst=1 are dropped and not counted, except RST_KEY.
- Match rules on an accepted byte:
  - RST_KEY takes priority over channel keys.
  - Among duplicate keys, the lowest channel index wins. Only one channel is triggered per byte.
- Channel hit i:
  - hcnt[i] <= HOLD_CYCLES; btn[i] <= 1.
  - If PAIR_EXCL=1, partner channel (i^1, if it exists) is cleared the same edge: hcnt <= 0, btn <= 0.
  - cmd_count++; last_cmd <= rx_data.
- Idle channel: if hcnt[i] > 0, it decrements each cycle. btn[i] <= (hcnt[i] > 1) when not hit, so btn falls on the edge where hcnt goes 1 -> 0.
- RST_KEY:
  - All hcnt and btn are cleared.
  - Reset counter <= RST_PULSE_CYCLES; game_rst <= 1.
  - cmd_count++; last_cmd <= RST_KEY.
  - A repeated RST_KEY during the pulse reloads the counter.
- game_rst stays high while the reset counter > 1 after load, so the pulse lasts exactly RST_PULSE_CYCLES cycles.
- Unmatched accepted byte: err_count++; no other state change.
- Counters saturate at 255; they do not wrap.
- rx_valid high on consecutive cycles: each cycle is a separate byte.

## Timing
- rst=1 at an edge: btn=0, game_rst=0, last_cmd=0, cmd_count=0, err_count=0, all hcnt=0 after that edge. This overrides any simultaneous rx_valid and applies mid-hold or mid-pulse.
- Latency: byte strobed at edge N -> btn/game_rst/counters updated at edge N+1 (one register stage, no combinational path from rx to outputs).
- Single key press: btn[i] high for exactly HOLD_CYCLES cycles (edges N+1 .. N+HOLD_CYCLES).
- Retrigger at cycle k while held: btn[i] stays high through k+HOLD_CYCLES with no glitch low.
- HOLD_CYCLES=1: one-cycle pulse per key. Back-to-back strobes give a continuous high.
- Partner exclusion takes effect on the same edge as the hit; the two channels are never high together.

## Test plan
- HOLD_CYCLES=8: strobe 'a' once -> btn=0001 for exactly 8 cycles starting one cycle after the strobe; cmd_count=1, last_cmd=0x61.
- Strobe 'a', then 'a' again 5 cycles later -> btn[0] high continuously for 13 cycles. Strobe 'q' while 'a' is held -> btn goes 0001 -> 0010 in one edge, never 0011.
- RST_PULSE_CYCLES=4: hold 'l' and 'p' active, strobe 'b' -> btn=0000 and game_rst high for exactly 4 cycles. 'a' strobed during the pulse is ignored (cmd_count unchanged); 'b' strobed during the pulse extends it.
- Strobe 'z' 300 times -> err_count=255 (saturates), btn unchanged, last_cmd unchanged.
- Assert rst mid-hold and mid-pulse, simultaneous with rx_valid='a' -> all outputs 0 the next cycle; no press recorded.
- PAIR_EXCL=0, KEY_MAP with duplicate 'a' on ch0 and ch2 -> only btn[0] asserts; strobing 'a' then 'q' -> btn=0011.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// UART command decoder: turns received key bytes into held button levels,
// with optional up/down pair exclusion and a stretched game-reset pulse.
module uart_cmd_decoder #(
  parameter int                  NUM_CH           = 4,
  parameter logic [8*NUM_CH-1:0] KEY_MAP          = {"p", "l", "q", "a"},
  parameter logic [7:0]          RST_KEY          = "b",
  parameter int                  HOLD_CYCLES      = 2500000,
  parameter int                  RST_PULSE_CYCLES = 16,
  parameter bit                  PAIR_EXCL        = 1'b1
) (
  input  logic              clk25MHz,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [NUM_CH-1:0] btn,
  output logic              game_rst,
  output logic [7:0]        last_cmd,
  output logic [7:0]        cmd_count,
  output logic [7:0]        err_count
);

  localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int RCNT_W = $clog2(RST_PULSE_CYCLES + 1);

  localparam logic [HCNT_W-1:0] HOLD_LOAD = HCNT_W'(HOLD_CYCLES);
  localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);
  localparam logic [RCNT_W-1:0] RST_LOAD  = RCNT_W'(RST_PULSE_CYCLES);
  localparam logic [RCNT_W-1:0] RCNT_ONE  = RCNT_W'(1);

  logic [HCNT_W-1:0] hcnt_q [NUM_CH];
  logic [HCNT_W-1:0] hcnt_d [NUM_CH];
  logic [NUM_CH-1:0] btn_q, btn_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              game_rst_q, game_rst_d;
  logic [7:0]        last_cmd_q, last_cmd_d;
  logic [7:0]        cmd_count_q, cmd_count_d;
  logic [7:0]        err_count_q, err_count_d;

  logic              is_rst_key;
  logic              accept;
  logic [NUM_CH-1:0] match;
  logic [NUM_CH-1:0] hit_oh;
  logic [NUM_CH:0]   hit_pad;
  logic              any_hit;

  // Byte classification. RST_KEY is honoured even during the pulse so it can
  // extend it; every other byte is dropped while game_rst is high.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    match      = '0;
    hit_oh     = '0;
    any_hit    = 1'b0;
    is_rst_key = rx_valid && (rx_data == RST_KEY);
    accept     = rx_valid && !game_rst_q && !is_rst_key;
    for (int i = 0; i < NUM_CH; i++) begin
      match[i] = (rx_data == KEY_MAP[8*i +: 8]);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (accept && match[i] && !any_hit) begin
        hit_oh[i] = 1'b1;
        any_hit   = 1'b1;
      end
    end
    // Padding bit lets channel i look at partner i^1 without an out-of-range index.
    hit_pad = {1'b0, hit_oh};
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      hcnt_d[i] = hcnt_q[i];
      btn_d[i]  = 1'b0;
      if (hcnt_q[i] != '0) begin
        hcnt_d[i] = hcnt_q[i] - HCNT_ONE;
        btn_d[i]  = (hcnt_q[i] > HCNT_ONE);
      end
      if (hit_oh[i]) begin
        hcnt_d[i] = HOLD_LOAD;
        btn_d[i]  = 1'b1;
      end else if (PAIR_EXCL && hit_pad[i ^ 1]) begin
        hcnt_d[i] = '0;
        btn_d[i]  = 1'b0;
      end
      if (is_rst_key) begin
        hcnt_d[i] = '0;
        btn_d[i]  = 1'b0;
      end
    end
  end

  always_comb begin
    rcnt_d      = rcnt_q;
    game_rst_d  = 1'b0;
    last_cmd_d  = last_cmd_q;
    cmd_count_d = cmd_count_q;
    err_count_d = err_count_q;
    if (rcnt_q != '0) begin
      rcnt_d     = rcnt_q - RCNT_ONE;
      game_rst_d = (rcnt_q > RCNT_ONE);
    end
    if (is_rst_key) begin
      rcnt_d     = RST_LOAD;
      game_rst_d = 1'b1;
    end
    if (is_rst_key || any_hit) begin
      last_cmd_d = rx_data;
      if (cmd_count_q != 8'hFF) cmd_count_d = cmd_count_q + 8'd1;
    end else if (accept) begin
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk25MHz) begin
    if (rst) begin
      // NOTE: the hold counters are a handful of flops, not RAM, so they are reset like any register.
      for (int i = 0; i < NUM_CH; i++) hcnt_q[i] <= '0;
      btn_q       <= '0;
      rcnt_q      <= '0;
      game_rst_q  <= 1'b0;
      last_cmd_q  <= 8'h00;
      cmd_count_q <= 8'h00;
      err_count_q <= 8'h00;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge value of the others.
      for (int i = 0; i < NUM_CH; i++) hcnt_q[i] <= hcnt_d[i];
      btn_q       <= btn_d;
      rcnt_q      <= rcnt_d;
      game_rst_q  <= game_rst_d;
      last_cmd_q  <= last_cmd_d;
      cmd_count_q <= cmd_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign btn       = btn_q;
  assign game_rst  = game_rst_q;
  assign last_cmd  = last_cmd_q;
  assign cmd_count = cmd_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: three parameterisations share one
// byte stream; a deadline-based reference model predicts every cycle.
module tb_uart_cmd_decoder;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic       rst      = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data  = 8'h00;

  logic [3:0] btn_a, btn_b, btn_c;
  logic       grst_a, grst_b, grst_c;
  logic [7:0] last_a, last_b, last_c;
  logic [7:0] cmd_a, cmd_b, cmd_c;
  logic [7:0] err_a, err_b, err_c;

  localparam logic [31:0] MAP_STD = {"p", "l", "q", "a"};
  localparam logic [31:0] MAP_DUP = {"p", "a", "q", "a"};

  uart_cmd_decoder #(.NUM_CH(4), .KEY_MAP(MAP_STD), .RST_KEY("b"), .HOLD_CYCLES(8),
                     .RST_PULSE_CYCLES(4), .PAIR_EXCL(1'b1)) u_a (
    .clk25MHz(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .btn(btn_a), .game_rst(grst_a), .last_cmd(last_a), .cmd_count(cmd_a), .err_count(err_a));

  uart_cmd_decoder #(.NUM_CH(4), .KEY_MAP(MAP_DUP), .RST_KEY("b"), .HOLD_CYCLES(8),
                     .RST_PULSE_CYCLES(4), .PAIR_EXCL(1'b0)) u_b (
    .clk25MHz(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .btn(btn_b), .game_rst(grst_b), .last_cmd(last_b), .cmd_count(cmd_b), .err_count(err_b));

  uart_cmd_decoder #(.NUM_CH(4), .KEY_MAP(MAP_STD), .RST_KEY("b"), .HOLD_CYCLES(1),
                     .RST_PULSE_CYCLES(1), .PAIR_EXCL(1'b1)) u_c (
    .clk25MHz(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .btn(btn_c), .game_rst(grst_c), .last_cmd(last_c), .cmd_count(cmd_c), .err_count(err_c));

  typedef struct {
    int         inst;
    longint     t;
    logic [3:0] btn;
    logic       grst;
    logic [7:0] last;
    logic [7:0] cmd;
    logic [7:0] err;
  } exp_t;

  exp_t sb[$];

  int          m_hold [3] = '{8, 8, 1};
  int          m_rpl  [3] = '{4, 4, 1};
  bit          m_px   [3] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] m_map  [3] = '{MAP_STD, MAP_DUP, MAP_STD};

  // Each channel is high while the cycle index is below its release time.
  longint     rel  [3][4];
  longint     grel [3];
  logic [7:0] m_last [3] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] m_cmd  [3] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] m_err  [3] = '{8'h00, 8'h00, 8'h00};
  bit         m_pg   [3] = '{1'b0, 1'b0, 1'b0};

  longint t = 0;
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int k, input bit v, input logic [7:0] d, input bit r);
    exp_t e;
    int   hit;
    if (r) begin
      for (int i = 0; i < 4; i++) rel[k][i] = 0;
      grel[k]   = 0;
      m_last[k] = 8'h00;
      m_cmd[k]  = 8'h00;
      m_err[k]  = 8'h00;
    end else if (v && d == 8'h62) begin
      for (int i = 0; i < 4; i++) rel[k][i] = 0;
      grel[k]   = t + m_rpl[k];
      m_last[k] = d;
      if (m_cmd[k] != 8'hFF) m_cmd[k] = m_cmd[k] + 8'd1;
    end else if (v && !m_pg[k]) begin
      hit = -1;
      for (int i = 0; i < 4; i++)
        if (hit < 0 && m_map[k][8*i +: 8] == d) hit = i;
      if (hit >= 0) begin
        rel[k][hit] = t + m_hold[k];
        if (m_px[k]) rel[k][hit ^ 1] = 0;
        m_last[k] = d;
        if (m_cmd[k] != 8'hFF) m_cmd[k] = m_cmd[k] + 8'd1;
      end else begin
        if (m_err[k] != 8'hFF) m_err[k] = m_err[k] + 8'd1;
      end
    end
    e.inst = k;
    e.t    = t;
    for (int i = 0; i < 4; i++) e.btn[i] = (t < rel[k][i]);
    e.grst = (t < grel[k]);
    e.last = m_last[k];
    e.cmd  = m_cmd[k];
    e.err  = m_err[k];
    m_pg[k] = e.grst;
    sb.push_back(e);
  endtask

  task automatic compare_pending();
    exp_t       e;
    logic [3:0] b;
    logic       g;
    logic [7:0] l, c, x;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.inst)
        0:       begin b = btn_a; g = grst_a; l = last_a; c = cmd_a; x = err_a; end
        1:       begin b = btn_b; g = grst_b; l = last_b; c = cmd_b; x = err_b; end
        default: begin b = btn_c; g = grst_c; l = last_c; c = cmd_c; x = err_c; end
      endcase
      check($sformatf("u%0d.btn@%0d", e.inst, e.t),      32'(b), 32'(e.btn));
      check($sformatf("u%0d.game_rst@%0d", e.inst, e.t), 32'(g), 32'(e.grst));
      check($sformatf("u%0d.last_cmd@%0d", e.inst, e.t), 32'(l), 32'(e.last));
      check($sformatf("u%0d.cmd_count@%0d", e.inst, e.t), 32'(c), 32'(e.cmd));
      check($sformatf("u%0d.err_count@%0d", e.inst, e.t), 32'(x), 32'(e.err));
      if (e.inst != 1)
        check($sformatf("u%0d.pair_overlap@%0d", e.inst, e.t), 32'(b[0] & b[1]), 32'd0);
    end
  endtask

  // Drive one cycle of stimulus; outputs of the previous edge are checked first.
  task automatic step(input bit v, input logic [7:0] d, input bit r);
    @(negedge clk);
    compare_pending();
    rst      = r;
    rx_valid = v;
    rx_data  = d;
    t++;
    for (int k = 0; k < 3; k++) model_step(k, v, d, r);
  endtask

  task automatic key(input logic [7:0] d);
    step(1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  logic [7:0] pool [8] = '{"a", "q", "l", "p", "b", "z", "x", "A"};
  int hi;

  initial begin
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, "a", 1'b1);
    idle(2);

    key("a");
    idle(10);

    hi = 0;
    key("a");
    if (btn_a[0]) hi++;
    for (int i = 0; i < 4; i++) begin idle(1); if (btn_a[0]) hi++; end
    key("a");
    if (btn_a[0]) hi++;
    for (int i = 0; i < 14; i++) begin idle(1); if (btn_a[0]) hi++; end
    check("retrigger_high_cycles", 32'(hi), 32'd13);

    key("a");
    idle(3);
    key("q");
    idle(10);

    key("l");
    key("p");
    idle(2);
    key("b");
    idle(1);
    key("a");
    key("b");
    idle(6);

    for (int i = 0; i < 300; i++) key("z");
    idle(1);
    check("err_saturate_u0", 32'(err_a), 32'd255);
    check("err_saturate_u2", 32'(err_c), 32'd255);
    idle(1);

    key("a");
    idle(3);
    step(1'b1, "a", 1'b1);
    idle(3);
    key("b");
    idle(1);
    step(1'b1, "a", 1'b1);
    idle(3);

    key("a");
    key("q");
    idle(10);

    for (int i = 0; i < 4; i++) key("a");
    idle(3);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 99) < 2)
        step(1'b0, 8'h00, 1'b1);
      else if ($urandom_range(0, 1) == 1)
        key(pool[$urandom_range(0, 7)]);
      else
        idle(1);
    end
    idle(12);

    @(negedge clk);
    compare_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
